// File: rtl/pred_stack_pkg.sv
// Shared SM definitions: lane count and the lane-mask type used by the CU,
// register file and the predicate stack.
package pred_stack_pkg;

  localparam int NUM_LANES = 8;

  typedef logic [NUM_LANES-1:0] lane_mask_t;

  localparam lane_mask_t MASK_ALL = '1;

endpackage

// File: rtl/pred_stack_mem.sv
// DEPTH x NUM_LANES mask array: one write port plus top/parent read ports
// indexed by the current stack depth.
module pred_stack_mem
  import pred_stack_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int DEPTH_W = $clog2(DEPTH + 1),
  parameter int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [AW-1:0]      waddr_i,
  input  lane_mask_t         wdata_i,
  input  logic [DEPTH_W-1:0] depth_i,
  output lane_mask_t         top_o,
  output lane_mask_t         parent_o
);

  lane_mask_t         mem_q [DEPTH];
  logic [AW-1:0]      top_idx;
  logic [AW-1:0]      par_idx;

  // Entries hold data only; depth alone decides validity, so no reset here.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign top_idx = AW'(depth_i - DEPTH_W'(1));
  assign par_idx = AW'(depth_i - DEPTH_W'(2));

  always_comb begin
    top_o    = MASK_ALL;
    parent_o = MASK_ALL;
    if (depth_i != '0) begin
      top_o = mem_q[top_idx];
    end
    if (depth_i >= DEPTH_W'(2)) begin
      parent_o = mem_q[par_idx];
    end
  end

endmodule

// File: rtl/pred_stack.sv
// Per-lane predicate register and branch-mask stack: strobe legality decode,
// depth counter, sticky error flags and branch-skip hints for the CU.
module pred_stack
  import pred_stack_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int DEPTH_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pred_we,
  input  lane_mask_t         pred_in,
  input  logic               pstack_push,
  input  logic               pstack_pop,
  input  logic               pstack_complement,
  output lane_mask_t         active_mask,
  output logic               all_mask_false,
  output logic               all_mask_true,
  output logic [DEPTH_W-1:0] depth,
  output logic               overflow,
  output logic               underflow,
  output logic               cmd_error
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(DEPTH);

  lane_mask_t         p_q, p_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic               cerr_q, cerr_d;

  lane_mask_t         top, parent;
  logic               multi, empty, full;
  logic               mem_we;
  logic [AW-1:0]      mem_waddr;
  lane_mask_t         mem_wdata;

  pred_stack_mem #(
    .DEPTH   (DEPTH),
    .DEPTH_W (DEPTH_W),
    .AW      (AW)
  ) u_mem (
    .clk      (clk),
    .we_i     (mem_we),
    .waddr_i  (mem_waddr),
    .wdata_i  (mem_wdata),
    .depth_i  (depth_q),
    .top_o    (top),
    .parent_o (parent)
  );

  assign multi = (pstack_push & pstack_pop) | (pstack_push & pstack_complement) |
                 (pstack_pop & pstack_complement);
  assign empty = (depth_q == '0);
  assign full  = (depth_q == DEPTH_MAX);

  always_comb begin
    p_d       = p_q;
    depth_d   = depth_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    cerr_d    = cerr_q;
    mem_we    = 1'b0;
    mem_waddr = AW'(depth_q);
    mem_wdata = top & p_q;

    if (pred_we) begin
      p_d = pred_in;
    end

    // Conflicting strobes perform nothing, even if one of them would be legal.
    if (multi) begin
      cerr_d = 1'b1;
    end else if (pstack_push) begin
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        mem_we    = 1'b1;
        mem_waddr = AW'(depth_q);
        mem_wdata = top & p_q;
        depth_d   = depth_q + DEPTH_W'(1);
      end
    end else if (pstack_pop) begin
      if (empty) begin
        unf_d = 1'b1;
      end else begin
        depth_d = depth_q - DEPTH_W'(1);
      end
    end else if (pstack_complement) begin
      if (empty) begin
        unf_d = 1'b1;
      end else begin
        mem_we    = 1'b1;
        mem_waddr = AW'(depth_q - DEPTH_W'(1));
        mem_wdata = parent & ~top;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_q     <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      cerr_q  <= 1'b0;
    end else begin
      p_q     <= p_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      cerr_q  <= cerr_d;
    end
  end

  // Hints come from registered state only so the CU can use them while decoding.
  assign active_mask    = top;
  assign all_mask_false = ((top & p_q) == '0);
  assign all_mask_true  = (top == parent);
  assign depth          = depth_q;
  assign overflow       = ovf_q;
  assign underflow      = unf_q;
  assign cmd_error      = cerr_q;

endmodule

// File: tb/tb_pred_stack.sv
// Directed bench for pred_stack with hand-computed expected masks and flags.
module tb_pred_stack;
  import pred_stack_pkg::*;

  localparam int DEPTH   = 8;
  localparam int DEPTH_W = $clog2(DEPTH + 1);

  logic               clk;
  logic               reset;
  logic               pred_we;
  lane_mask_t         pred_in;
  logic               pstack_push;
  logic               pstack_pop;
  logic               pstack_complement;
  lane_mask_t         active_mask;
  logic               all_mask_false;
  logic               all_mask_true;
  logic [DEPTH_W-1:0] depth;
  logic               overflow;
  logic               underflow;
  logic               cmd_error;

  int checks = 0;
  int errors = 0;

  pred_stack #(.DEPTH(DEPTH)) dut (
    .clk               (clk),
    .reset             (reset),
    .pred_we           (pred_we),
    .pred_in           (pred_in),
    .pstack_push       (pstack_push),
    .pstack_pop        (pstack_pop),
    .pstack_complement (pstack_complement),
    .active_mask       (active_mask),
    .all_mask_false    (all_mask_false),
    .all_mask_true     (all_mask_true),
    .depth             (depth),
    .overflow          (overflow),
    .underflow         (underflow),
    .cmd_error         (cmd_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock with the given strobes; outputs are settled 1ns after the edge.
  task automatic op(input logic push, input logic pop, input logic comp,
                    input logic we, input lane_mask_t pin);
    @(negedge clk);
    pstack_push       = push;
    pstack_pop        = pop;
    pstack_complement = comp;
    pred_we           = we;
    pred_in           = pin;
    @(posedge clk);
    #1;
    pstack_push       = 1'b0;
    pstack_pop        = 1'b0;
    pstack_complement = 1'b0;
    pred_we           = 1'b0;
  endtask

  task automatic setp(input lane_mask_t v);  op(0, 0, 0, 1, v);    endtask
  task automatic push();                     op(1, 0, 0, 0, 8'h00); endtask
  task automatic pop();                      op(0, 1, 0, 0, 8'h00); endtask
  task automatic comp();                     op(0, 0, 1, 0, 8'h00); endtask

  initial begin
    reset             = 1'b0;
    pred_we           = 1'b0;
    pred_in           = '0;
    pstack_push       = 1'b0;
    pstack_pop        = 1'b0;
    pstack_complement = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    chk("rst_mask", 32'(active_mask), 32'hFF);
    chk("rst_depth", 32'(depth), 0);
    chk("rst_amt", 32'(all_mask_true), 1);
    chk("rst_amf", 32'(all_mask_false), 1);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_unf", 32'(underflow), 0);
    chk("rst_cerr", 32'(cmd_error), 0);

    // Single level: push, complement twice, pop.
    setp(8'h0F);
    chk("p0f_amf", 32'(all_mask_false), 0);
    push();
    chk("push1_mask", 32'(active_mask), 32'h0F);
    chk("push1_depth", 32'(depth), 1);
    chk("push1_amt", 32'(all_mask_true), 0);
    comp();
    chk("comp1_mask", 32'(active_mask), 32'hF0);
    comp();
    chk("comp2_mask", 32'(active_mask), 32'h0F);
    pop();
    chk("pop1_mask", 32'(active_mask), 32'hFF);
    chk("pop1_depth", 32'(depth), 0);

    // Nested levels.
    push();
    chk("nest1_mask", 32'(active_mask), 32'h0F);
    setp(8'h03);
    push();
    chk("nest2_mask", 32'(active_mask), 32'h03);
    chk("nest2_depth", 32'(depth), 2);
    comp();
    chk("nest_comp", 32'(active_mask), 32'h0C);
    chk("nest_comp_depth", 32'(depth), 2);
    pop();
    chk("nest_pop1", 32'(active_mask), 32'h0F);
    pop();
    chk("nest_pop2", 32'(active_mask), 32'hFF);
    chk("nest_pop2_depth", 32'(depth), 0);

    // Branch-skip hints.
    setp(8'h00);
    chk("p00_amf", 32'(all_mask_false), 1);
    setp(8'hFF);
    chk("pff_amf", 32'(all_mask_false), 0);
    push();
    chk("pff_amt", 32'(all_mask_true), 1);
    chk("pff_mask", 32'(active_mask), 32'hFF);
    pop();

    // Overflow: nine pushes into eight entries.
    for (int i = 0; i < 9; i++) push();
    chk("ovf_depth", 32'(depth), 8);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_unf", 32'(underflow), 0);
    chk("ovf_mask", 32'(active_mask), 32'hFF);

    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("ovf_rst_depth", 32'(depth), 0);
    chk("ovf_rst_flag", 32'(overflow), 0);
    @(negedge clk);
    reset = 1'b1;

    pop();
    chk("unf_flag", 32'(underflow), 1);
    chk("unf_depth", 32'(depth), 0);
    comp();
    chk("unf_comp_depth", 32'(depth), 0);
    chk("unf_comp_mask", 32'(active_mask), 32'hFF);

    // Push with a same-cycle SETP uses the old P.
    setp(8'h0F);
    op(1, 0, 0, 1, 8'h33);
    chk("oldp_mask", 32'(active_mask), 32'h0F);
    chk("oldp_amf", 32'(all_mask_false), 0);
    chk("oldp_depth", 32'(depth), 1);

    // Conflicting strobes.
    op(1, 1, 0, 0, 8'h00);
    chk("cerr_depth", 32'(depth), 1);
    chk("cerr_mask", 32'(active_mask), 32'h0F);
    chk("cerr_flag", 32'(cmd_error), 1);
    op(0, 1, 1, 0, 8'h00);
    chk("cerr2_depth", 32'(depth), 1);
    chk("cerr2_mask", 32'(active_mask), 32'h0F);

    // Asynchronous reset mid-nest at depth 3.
    push();
    push();
    chk("deep_depth", 32'(depth), 3);
    chk("deep_mask", 32'(active_mask), 32'h03);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_depth", 32'(depth), 0);
    chk("async_mask", 32'(active_mask), 32'hFF);
    chk("async_cerr", 32'(cmd_error), 0);
    chk("async_unf", 32'(underflow), 0);
    chk("async_amf", 32'(all_mask_false), 1);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
